// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: 8 data bits, optional parity, one stop bit.
// Bit timing comes from an external 16x oversample tick.
module uart_tx_ctrl #(
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  input  logic       Tx_sample_ENABLE,
  output logic       TxD,
  output logic       Tx_BUSY,
  output logic       Tx_DONE
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [2:0] r_idx;
  logic [2:0] w_idx_nxt;
  logic [7:0] r_hold;
  logic [7:0] w_hold_nxt;
  logic       r_txd;
  logic       w_txd_nxt;
  logic       r_busy;
  logic       w_busy_nxt;
  logic       r_done;
  logic       w_done_nxt;

  logic       w_accept;
  logic       w_bit_end;
  logic       w_parity;
  logic [2:0] w_idx_inc;

  assign w_accept  = (r_state == IDLE) & Tx_EN & Tx_WR;
  assign w_bit_end = Tx_sample_ENABLE & (r_cnt == 4'd15);
  assign w_parity  = (^r_hold) ^ PARITY_ODD;
  assign w_idx_inc = r_idx + 3'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= 3'd0;
      r_hold  <= 8'd0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_hold  <= w_hold_nxt;
      r_txd   <= w_txd_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_hold_nxt  = r_hold;
    w_txd_nxt   = r_txd;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    // Counter wraps 15->0 on its own, so each bit period restarts at 0.
    if ((r_state != IDLE) && Tx_sample_ENABLE)
      w_cnt_nxt = r_cnt + 4'd1;

    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = START;
          w_hold_nxt  = Tx_DATA;
          w_cnt_nxt   = 4'd0;
          w_idx_nxt   = 3'd0;
          w_busy_nxt  = 1'b1;
          w_txd_nxt   = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_idx_nxt   = 3'd0;
          w_txd_nxt   = r_hold[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_idx != 3'd7) begin
            w_idx_nxt = w_idx_inc;
            w_txd_nxt = r_hold[w_idx_inc];
          end else if (PARITY_EN) begin
            w_state_nxt = PARITY;
            w_txd_nxt   = w_parity;
          end else begin
            w_state_nxt = STOP;
            w_txd_nxt   = 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = STOP;
          w_txd_nxt   = 1'b1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_txd_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  assign TxD     = r_txd;
  assign Tx_BUSY = r_busy;
  assign Tx_DONE = r_done;

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter PARITY_EN, default 1, meaning 1 = parity bit inserted after data bits, 0 = no parity bit.
REQ-002 Parameter PARITY_ODD, default 0, meaning 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 Tx_EN  input  1  transmitter enable; gates acceptance of new frames only.
REQ-006 Tx_WR  input  1  single-cycle write strobe requesting transmission of Tx_DATA.
REQ-007 Tx_DATA  input  8  byte to transmit; sampled only on an accepted write.
REQ-008 Tx_sample_ENABLE  input  1  16x-oversample tick from the baud controller, one clk wide.
REQ-009 TxD  output  1  serial line, idle high.
REQ-010 Tx_BUSY  output  1  high while a frame is in progress.
REQ-011 Tx_DONE  output  1  one-clk pulse at frame completion.

Function
REQ-012 The block SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-013 The block SHALL hold an internal 4-bit sample counter, a 3-bit bit index and an 8-bit shift/hold register.
REQ-014 A write SHALL be accepted only when state=IDLE, Tx_EN=1 and Tx_WR=1; all other Tx_WR assertions are ignored without side effect.
REQ-015 On an accepted write, at the next edge: state=START, Tx_DATA latched, sample counter=0, bit index=0, Tx_BUSY=1, TxD=0.
REQ-016 The sample counter SHALL increment only on Tx_sample_ENABLE=1 outside IDLE and wrap 15->0; a tick coincident with the accepting edge is not counted.
REQ-017 A bit period SHALL end on the edge where Tx_sample_ENABLE=1 and counter=15, giving exactly 16 ticks per bit.
REQ-018 Transitions at bit-period end: START->DATA; DATA->DATA while bit index<7 (index+1); DATA->PARITY when index=7 and PARITY_EN=1, else DATA->STOP; PARITY->STOP; STOP->IDLE.
REQ-019 TxD SHALL be registered: 1 in IDLE/STOP, 0 in START, latched bit[index] in DATA (LSB first), parity bit in PARITY.
REQ-020 Parity bit SHALL be XOR-reduction of the latched byte, inverted when PARITY_ODD=1.
REQ-021 On STOP->IDLE edge: Tx_BUSY=0 and Tx_DONE=1 for exactly one clk; Tx_DONE=0 at all other times.
REQ-022 Tx_WR on the same cycle Tx_DONE is high SHALL be accepted (state already IDLE); Tx_WR on the cycle before it (state STOP) SHALL be ignored.
REQ-023 Deasserting Tx_EN mid-frame SHALL NOT abort the frame; the frame completes normally.
REQ-024 Changes on Tx_DATA while Tx_BUSY=1 SHALL NOT affect the frame in progress.
REQ-025 Frame length SHALL be 176 ticks with parity, 160 without; clk cycles without ticks do not advance the frame.

Reset
REQ-026 reset=1 SHALL immediately force state=IDLE, counter=0, bit index=0, hold register=0, TxD=1, Tx_BUSY=0, Tx_DONE=0, regardless of clk.
REQ-027 Reset mid-frame SHALL abandon the frame with no Tx_DONE pulse; first write after reset release starts a fresh frame.

Verification
REQ-028 Tx_EN=1, write 0xA5, PARITY_EN=1 even, tick every 4 clk -> TxD 0,1,0,1,0,0,1,0,1,0,1 each held 16 ticks, Tx_DONE pulse after 176th tick.
REQ-029 Same byte with PARITY_ODD=1 -> parity bit 1; with PARITY_EN=0 -> 10-bit frame, Tx_DONE after 160th tick.
REQ-030 Tx_WR pulsed mid-DATA with Tx_DATA=0xFF -> ignored, in-flight frame bits unchanged, Tx_BUSY stays 1.
REQ-031 Tx_EN=0 with Tx_WR=1 in IDLE -> no frame, TxD=1, Tx_BUSY=0; Tx_EN dropped mid-frame -> frame completes.
REQ-032 Assert reset during DATA bit 3 -> TxD=1, Tx_BUSY=0 before next clk edge, no Tx_DONE; then write 0x3C -> full correct frame.
REQ-033 Tx_WR=1 on Tx_DONE cycle with 0x01 -> back-to-back frame: START begins next edge, single idle-high cycle between frames.
